// File: rtl/cam_multibank_capture.sv
// cam_multibank_capture: packs camera pixels into words and writes them round-robin into NBANKS RAM banks,
// holding each closed bank until the host releases it and dropping words rather than overwriting.
module cam_multibank_capture #(
    parameter int PIX_W   = 8,
    parameter int WORD_W  = 32,
    parameter int NBANKS  = 4,
    parameter int BANK_AW = 9,
    parameter bit VS_POL  = 1'b1,
    parameter bit HR_POL  = 1'b1
) (
    input  logic                      PCLKI,
    input  logic                      WBs_RST_i,
    input  logic                      VSYNCI,
    input  logic                      HREFI,
    input  logic [PIX_W-1:0]          PIX_DAT_i,
    input  logic                      cap_en_i,
    input  logic [NBANKS-1:0]         bank_rel_i,
    input  logic                      ovf_clr_i,
    output logic [BANK_AW-1:0]        ram_wa_o,
    output logic [WORD_W-1:0]         ram_wd_o,
    output logic [NBANKS-1:0]         ram_we_o,
    output logic [NBANKS-1:0]         bank_full_o,
    output logic [$clog2(NBANKS)-1:0] cur_bank_o,
    output logic [15:0]               frame_cnt_o,
    output logic [15:0]               line_cnt_o,
    output logic                      ovf_o
);
    localparam int PPW = WORD_W / PIX_W;
    localparam int PCW = PPW > 1 ? $clog2(PPW) : 1;

    typedef enum logic [1:0] {IDLE, ARM, CAPT, DROP} state_t;
    state_t st, st_nxt;

    logic vs, hr, vs_q, hr_q, fs, fe, le, cap_st, active, pix_ok, last;
    logic word_done, partial, tgt_full, wr, drop, adv;
    logic [PCW-1:0]     pix_cnt;
    logic [WORD_W-1:0]  wbuf, buf_nxt, wr_word;
    logic [BANK_AW-1:0] wa;
    logic [NBANKS-1:0]  set_mask;

    assign vs        = VSYNCI ~^ VS_POL;
    assign hr        = HREFI ~^ HR_POL;
    assign cap_st    = (st == CAPT) || (st == DROP);
    assign fs        = vs & ~vs_q;
    assign fe        = cap_st & vs_q & ~vs;
    assign le        = hr_q & ~hr & vs;
    // the pixel coinciding with the frame-start edge already belongs to the captured frame
    assign active    = cap_st | ((st == ARM) & fs & cap_en_i);
    assign pix_ok    = active & vs & hr;
    assign last      = pix_cnt == PCW'(PPW - 1);
    assign word_done = pix_ok & last;
    assign partial   = pix_cnt != '0;
    assign tgt_full  = bank_full_o[cur_bank_o];
    assign buf_nxt   = wbuf | (WORD_W'(PIX_DAT_i) << (PIX_W * (PPW - 1 - int'(pix_cnt))));
    assign wr_word   = fe ? wbuf : buf_nxt;
    assign wr        = (word_done | (fe & partial)) & ~tgt_full;
    assign drop      = (word_done | (fe & partial)) & tgt_full;
    // a bank closes on address wrap, or at frame end unless it is still empty
    assign adv       = (wr & (&wa)) | (fe & (wr | (wa != '0)));
    assign set_mask  = adv ? NBANKS'(1) << cur_bank_o : '0;

    always_comb begin
        st_nxt = st;
        unique case (st)
            IDLE:    st_nxt = cap_en_i ? ARM : IDLE;
            ARM:     st_nxt = (fs && cap_en_i) ? CAPT : ARM;
            CAPT:    st_nxt = fe ? ARM : (word_done && tgt_full) ? DROP : CAPT;
            DROP:    st_nxt = fe ? ARM : (word_done && !tgt_full) ? CAPT : DROP;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLKI or posedge WBs_RST_i)
        if (WBs_RST_i) st <= IDLE;
        else st <= st_nxt;

    always_ff @(posedge PCLKI or posedge WBs_RST_i)
        if (WBs_RST_i) begin
            vs_q        <= 1'b0;
            hr_q        <= 1'b0;
            pix_cnt     <= '0;
            wbuf        <= '0;
            wa          <= '0;
            ram_wa_o    <= '0;
            ram_wd_o    <= '0;
            ram_we_o    <= '0;
            bank_full_o <= '0;
            cur_bank_o  <= '0;
            frame_cnt_o <= '0;
            line_cnt_o  <= '0;
            ovf_o       <= 1'b0;
        end else begin
            vs_q        <= vs;
            hr_q        <= hr;
            ram_we_o    <= wr ? NBANKS'(1) << cur_bank_o : '0;
            ram_wa_o    <= wr ? wa : ram_wa_o;
            ram_wd_o    <= wr ? wr_word : ram_wd_o;
            wa          <= adv ? '0 : wr ? wa + 1'b1 : wa;
            cur_bank_o  <= adv ? cur_bank_o + 1'b1 : cur_bank_o;
            bank_full_o <= (bank_full_o & ~bank_rel_i) | set_mask;
            ovf_o       <= drop | (ovf_o & ~ovf_clr_i);
            frame_cnt_o <= fe ? frame_cnt_o + 16'd1 : frame_cnt_o;
            line_cnt_o  <= fs ? 16'd0 : (cap_st && le) ? line_cnt_o + 16'd1 : line_cnt_o;
            if (!active || fe) begin
                pix_cnt <= '0;
                wbuf    <= '0;
            end else if (pix_ok) begin
                pix_cnt <= last ? '0 : pix_cnt + 1'b1;
                wbuf    <= last ? '0 : buf_nxt;
            end
        end
endmodule

// File: tb/tb_cam_multibank_capture.sv
// tb_cam_multibank_capture: scoreboard bench; a behavioural bank/packing model queues expected RAM writes
// and a negedge monitor pops and compares them as ram_we_o fires.
module tb_cam_multibank_capture;
    logic        PCLKI, WBs_RST_i, VSYNCI, HREFI, cap_en_i, ovf_clr_i;
    logic [7:0]  PIX_DAT_i;
    logic [3:0]  bank_rel_i, ram_we_o, bank_full_o;
    logic [8:0]  ram_wa_o;
    logic [31:0] ram_wd_o;
    logic [1:0]  cur_bank_o;
    logic [15:0] frame_cnt_o, line_cnt_o;
    logic        ovf_o;

    cam_multibank_capture dut (
        .PCLKI(PCLKI), .WBs_RST_i(WBs_RST_i), .VSYNCI(VSYNCI), .HREFI(HREFI), .PIX_DAT_i(PIX_DAT_i),
        .cap_en_i(cap_en_i), .bank_rel_i(bank_rel_i), .ovf_clr_i(ovf_clr_i), .ram_wa_o(ram_wa_o),
        .ram_wd_o(ram_wd_o), .ram_we_o(ram_we_o), .bank_full_o(bank_full_o), .cur_bank_o(cur_bank_o),
        .frame_cnt_o(frame_cnt_o), .line_cnt_o(line_cnt_o), .ovf_o(ovf_o)
    );

    initial PCLKI = 1'b0;
    always #5 PCLKI = ~PCLKI;

    typedef struct {int bank; int wa; logic [31:0] wd;} exp_t;
    exp_t q[$];
    int n_cmp = 0, n_err = 0, n_wr = 0;

    int m_bank, m_wa, m_pc;
    logic [31:0] m_word;
    bit m_full[4];
    bit m_cap;

    always @(negedge PCLKI) begin
        if (!WBs_RST_i && ram_we_o != 4'b0) begin
            n_cmp++;
            n_wr++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected got we=%b wa=%h wd=%h, required no write", ram_we_o, ram_wa_o, ram_wd_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (ram_we_o !== 4'(1 << e.bank) || ram_wa_o !== 9'(e.wa) || ram_wd_o !== e.wd) begin
                    n_err++;
                    $display("FAIL wr_data got we=%b wa=%h wd=%h, required we=%b wa=%h wd=%h",
                             ram_we_o, ram_wa_o, ram_wd_o, 4'(1 << e.bank), 9'(e.wa), e.wd);
                end
            end
        end
    end

    function automatic void m_emit();
        if (!m_full[m_bank]) begin
            q.push_back('{m_bank, m_wa, m_word});
            if (m_wa == 511) begin
                m_full[m_bank] = 1'b1;
                m_bank = (m_bank + 1) % 4;
                m_wa = 0;
            end else m_wa++;
        end
        m_word = 32'h0;
        m_pc = 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge PCLKI);
            HREFI = 1'b0;
        end
    endtask

    task automatic do_reset();
        WBs_RST_i = 1'b1; VSYNCI = 1'b0; HREFI = 1'b0; PIX_DAT_i = 8'h0;
        cap_en_i = 1'b0; bank_rel_i = 4'h0; ovf_clr_i = 1'b0;
        repeat (3) @(negedge PCLKI);
        WBs_RST_i = 1'b0;
        q.delete();
        m_bank = 0; m_wa = 0; m_pc = 0; m_word = 32'h0; m_cap = 1'b0;
        foreach (m_full[i]) m_full[i] = 1'b0;
        n_wr = 0;
    endtask

    task automatic arm();
        @(negedge PCLKI);
        cap_en_i = 1'b1;
        idle(2);
    endtask

    task automatic frame_start();
        @(negedge PCLKI);
        VSYNCI = 1'b1;
        HREFI = 1'b0;
        m_cap = cap_en_i;
        m_pc = 0;
        m_word = 32'h0;
    endtask

    task automatic pix(input logic [7:0] d);
        @(negedge PCLKI);
        HREFI = 1'b1;
        PIX_DAT_i = d;
        if (m_cap) begin
            m_word[(3 - m_pc) * 8 +: 8] = d;
            m_pc++;
            if (m_pc == 4) m_emit();
        end
    endtask

    task automatic stream(input int nwords, input int seed);
        for (int i = 0; i < nwords * 4; i++) pix(8'(seed + i * 7));
        idle(2);
    endtask

    task automatic frame_end();
        @(negedge PCLKI);
        HREFI = 1'b0;
        @(negedge PCLKI);
        VSYNCI = 1'b0;
        if (m_cap) begin
            if (m_pc != 0) m_emit();
            if (m_wa != 0) begin
                m_full[m_bank] = 1'b1;
                m_bank = (m_bank + 1) % 4;
                m_wa = 0;
            end
        end
        m_cap = 1'b0;
        idle(3);
    endtask

    task automatic rel(input int b);
        @(negedge PCLKI);
        bank_rel_i = 4'(1 << b);
        m_full[b] = 1'b0;
        @(negedge PCLKI);
        bank_rel_i = 4'h0;
    endtask

    task automatic test_reset();
        do_reset();
        idle(1);
        n_cmp++;
        if ({ram_wa_o, ram_wd_o, ram_we_o, bank_full_o, cur_bank_o, frame_cnt_o, line_cnt_o, ovf_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got wa=%h wd=%h we=%b full=%b cur=%0d fc=%0d lc=%0d ovf=%b, required all 0",
                     ram_wa_o, ram_wd_o, ram_we_o, bank_full_o, cur_bank_o, frame_cnt_o, line_cnt_o, ovf_o);
        end
    endtask

    task automatic test_line();
        do_reset();
        arm();
        frame_start();
        for (int i = 1; i <= 8; i++) pix(8'(i));
        idle(3);
        n_cmp++;
        if (line_cnt_o !== 16'd1) begin n_err++; $display("FAIL line_cnt got %0d required 1", line_cnt_o); end
        n_cmp++;
        if (n_wr !== 2 || q.size() != 0) begin
            n_err++; $display("FAIL line_writes got %0d writes, %0d pending, required 2 and 0", n_wr, q.size());
        end
        frame_end();
    endtask

    task automatic test_wrap();
        do_reset();
        arm();
        frame_start();
        stream(512, 3);
        n_cmp++;
        if (n_wr !== 512) begin n_err++; $display("FAIL wrap_count got %0d required 512", n_wr); end
        n_cmp++;
        if (bank_full_o !== 4'b0001 || cur_bank_o !== 2'd1) begin
            n_err++; $display("FAIL wrap_bank got full=%b cur=%0d required 0001 and 1", bank_full_o, cur_bank_o);
        end
        stream(1, 9);
        n_cmp++;
        if (q.size() != 0) begin n_err++; $display("FAIL wrap_pending got %0d required 0", q.size()); end
    endtask

    task automatic test_overflow();
        stream(1535, 21);
        n_cmp++;
        if (bank_full_o !== 4'b1111 || cur_bank_o !== 2'd0 || ovf_o !== 1'b0) begin
            n_err++; $display("FAIL ovf_allfull got full=%b cur=%0d ovf=%b required 1111 0 0", bank_full_o, cur_bank_o, ovf_o);
        end
        n_wr = 0;
        stream(3, 40);
        n_cmp++;
        if (ovf_o !== 1'b1 || n_wr !== 0) begin
            n_err++; $display("FAIL ovf_drop got ovf=%b writes=%0d required 1 and 0", ovf_o, n_wr);
        end
        rel(0);
        stream(1, 77);
        n_cmp++;
        if (n_wr !== 1 || ovf_o !== 1'b1 || q.size() != 0) begin
            n_err++; $display("FAIL ovf_release got writes=%0d ovf=%b pending=%0d required 1 1 0", n_wr, ovf_o, q.size());
        end
        @(negedge PCLKI);
        ovf_clr_i = 1'b1;
        @(negedge PCLKI);
        ovf_clr_i = 1'b0;
        n_cmp++;
        if (ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b required 0", ovf_o); end
        frame_end();
    endtask

    task automatic test_partial();
        do_reset();
        arm();
        frame_start();
        for (int i = 1; i <= 6; i++) pix(8'(i));
        frame_end();
        n_cmp++;
        if (bank_full_o !== 4'b0001 || cur_bank_o !== 2'd1) begin
            n_err++; $display("FAIL partial_bank got full=%b cur=%0d required 0001 and 1", bank_full_o, cur_bank_o);
        end
        n_cmp++;
        if (frame_cnt_o !== 16'd1 || line_cnt_o !== 16'd1) begin
            n_err++; $display("FAIL partial_counts got fc=%0d lc=%0d required 1 and 1", frame_cnt_o, line_cnt_o);
        end
        n_cmp++;
        if (n_wr !== 2 || q.size() != 0) begin
            n_err++; $display("FAIL partial_writes got %0d writes %0d pending required 2 0", n_wr, q.size());
        end
    endtask

    task automatic test_cap_en();
        do_reset();
        arm();
        cap_en_i = 1'b0;
        frame_start();
        pix(8'h11); pix(8'h12);
        cap_en_i = 1'b1;
        for (int i = 0; i < 6; i++) pix(8'(8'h20 + i));
        frame_end();
        n_cmp++;
        if (n_wr !== 0 || frame_cnt_o !== 16'd0) begin
            n_err++; $display("FAIL capen_skip got writes=%0d fc=%0d required 0 0", n_wr, frame_cnt_o);
        end
        frame_start();
        for (int i = 0; i < 8; i++) pix(8'(8'h40 + i));
        frame_end();
        n_cmp++;
        if (n_wr !== 2 || q.size() != 0 || frame_cnt_o !== 16'd1) begin
            n_err++; $display("FAIL capen_next got writes=%0d pending=%0d fc=%0d required 2 0 1", n_wr, q.size(), frame_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        arm();
        frame_start();
        for (int i = 1; i <= 4; i++) pix(8'(i));
        idle(1);
        pix(8'h05); pix(8'h06);
        n_cmp++;
        if (line_cnt_o !== 16'd1) begin n_err++; $display("FAIL rstmid_pre got lc=%0d required 1", line_cnt_o); end
        @(negedge PCLKI);
        #2 WBs_RST_i = 1'b1;
        #1;
        n_cmp++;
        if ({ram_wa_o, ram_wd_o, ram_we_o, bank_full_o, cur_bank_o, frame_cnt_o, line_cnt_o, ovf_o} !== '0) begin
            n_err++; $display("FAIL rstmid_async got wd=%h lc=%0d required all 0", ram_wd_o, line_cnt_o);
        end
        do_reset();
        arm();
        frame_start();
        pix(8'hA1); pix(8'hA2); pix(8'hA3); pix(8'hA4);
        frame_end();
        n_cmp++;
        if (n_wr !== 1 || q.size() != 0) begin
            n_err++; $display("FAIL rstmid_after got writes=%0d pending=%0d required 1 0", n_wr, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_wrap();
        test_overflow();
        test_partial();
        test_cap_en();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
